conv_ifmap_streamer: RTL and testbench
======================================

// Module: conv_ifmap_streamer
// PURPOSE
// - Transmit side of the conv pixel-stream interface: fetches the 3x3 kernel and an ifmap from on-chip SRAM,
//   drives kernel_num, a one-cycle conv_start pulse, then the raster pixel stream conv_num/conv_num_valid.
// - Streams the frame as overlapping row strips, waiting for the conv engine's done pulse between strips
//   (the interface has no backpressure). Sits between the accelerator SRAM read port and the conv control block.
// PARAMETERS
// - DATA_W      16  pixel/weight width
// - ADDR_W      16  SRAM word-address width
// - IMG_W       4   pixels per row (equals conv line-buffer length)
// - STRIP_ROWS  4   rows per strip; strip s starts at row s (row stride 1)
// - NUM_STRIPS  2   strips per frame
// PORTS
// - clk             in   1          clock
// - rst_n           in   1          async active-low reset
// - cfg_start       in   1          pulse: begin frame (sampled only in IDLE)
// - cfg_abort       in   1          sync abort, returns to IDLE next cycle
// - cfg_ifmap_base  in   ADDR_W     word address of pixel (0,0)
// - cfg_kern_base   in   ADDR_W     word address of weight 0 (9 consecutive words)
// - mem_en          out  1          SRAM read enable
// - mem_addr        out  ADDR_W     SRAM read address
// - mem_rdata       in   DATA_W     SRAM data, valid exactly 1 cycle after mem_en
// - kernel_num      out  9xDATA_W   packed weights [8:0][DATA_W-1:0], index k = word k
// - conv_start      out  1          one-cycle start pulse to conv engine
// - conv_num        out  DATA_W     pixel
// - conv_num_valid  out  1          pixel qualifier
// - conv_done       in   1          strip-complete pulse from conv engine
// - busy            out  1          high in every state except IDLE
// - frame_done      out  1          one-cycle pulse after last strip's conv_done
// BEHAVIOUR
// - Reset: all outputs 0, kernel_num all 0, state IDLE, counters 0, done_seen 0.
// - FSM: IDLE -> KLOAD -> KDRAIN -> START -> STREAM -> SDRAIN -> WAIT -> (START | FIN) -> IDLE.
// - IDLE: on cfg_start latch both bases, strip=0, go KLOAD; cfg_start in other states ignored.
// - KLOAD: 9 cycles, mem_en=1, mem_addr=kern_base+k (k=0..8); rdata captured into kernel_num[k] one cycle
//   later. KDRAIN: 1 cycle capturing word 8. kernel_num holds until next frame's KLOAD.
// - START: conv_start=1 for exactly 1 cycle; clear done_seen; pix=0.
// - STREAM: IMG_W*STRIP_ROWS cycles, mem_en=1, mem_addr=ifmap_base+strip*IMG_W+pix, pix++ (ADDR_W wrap
//   modulo 2^ADDR_W). Pipeline: conv_num<=mem_rdata, conv_num_valid<=mem_en-delayed; first conv_num_valid
//   2 cycles after first STREAM cycle; valid contiguous for exactly IMG_W*STRIP_ROWS cycles.
// - SDRAIN: 2 cycles, no new reads, flush pipeline; conv_num_valid falls, conv_num returns to 0 when invalid.
// - WAIT: stay until done_seen. done_seen is sticky set by conv_done in STREAM/SDRAIN/WAIT, so an early
//   done is not lost; conv_done in IDLE/KLOAD/KDRAIN/START/FIN ignored.
//   strip<NUM_STRIPS-1 -> strip++, START; else FIN.
// - FIN: frame_done=1 one cycle, -> IDLE. busy deasserts same cycle frame_done is high? No: busy low from IDLE.
// - cfg_abort (any non-IDLE state, highest priority): next cycle IDLE, mem_en=0, conv_num_valid=0,
//   pipeline flushed, no frame_done, kernel_num retained.
// - Simultaneous cfg_start and cfg_abort in IDLE: abort wins, stay IDLE.
// - Async reset mid-frame: immediate return to reset values; no partial pulses.
// - Frame length per strip = IMG_W*STRIP_ROWS; total reads = 9 + NUM_STRIPS*IMG_W*STRIP_ROWS.
// STRUCTURE
// - Shared package conv_pkg: DATA_W/ADDR_W defaults, state enum stream_state_e, kernel type
//   typedef logic [8:0][DATA_W-1:0] kernel_t (also used by conv control).
// - One sub-module: conv_rd_pipe (1-cycle SRAM latency valid/data alignment + output register, flushable).
// TESTING
// - Kernel load: weights 1..9 at kern_base 0x100 -> 9 reads 0x100..0x108, kernel_num[k]=k+1 before conv_start.
// - Single strip: ifmap pixels = address, base 0x0, NUM_STRIPS=1 -> 16 contiguous valids carrying 0..15,
//   then frame_done 1 cycle after conv_done.
// - Two strips: conv_done after each -> strip 1 streams 4..19; exactly two conv_start pulses.
// - Early done: conv_done during STREAM of strip 0 -> WAIT exits immediately, no hang.
// - Abort at pixel 7: cfg_abort -> next cycle mem_en=0, valid low within 2 cycles, no frame_done, busy=0.
// - Reset mid-STREAM and base 0xFFFE wrap: addresses 0xFFFE,0xFFFF,0x0000...; reset clears all outputs.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types for the conv pixel-stream datapath: default widths, the
// ifmap streamer state encoding and the packed 3x3 kernel type.
package conv_pkg;

    localparam int CONV_DATA_W = 16;
    localparam int CONV_ADDR_W = 16;
    localparam int KERN_TAPS   = 9;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_KLOAD  = 3'd1,
        S_KDRAIN = 3'd2,
        S_START  = 3'd3,
        S_STREAM = 3'd4,
        S_SDRAIN = 3'd5,
        S_WAIT   = 3'd6,
        S_FIN    = 3'd7
    } stream_state_e;

    typedef logic [KERN_TAPS-1:0][CONV_DATA_W-1:0] kernel_t;

endpackage

// File: rtl/conv_rd_pipe.sv
// Aligns SRAM read data (one cycle latency) with its read strobe and
// registers the result onto the pixel stream. A flush kills everything in
// flight so the qualifier drops on the very next cycle. Data is forced to 0
// whenever it is not qualified.
module conv_rd_pipe #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid
);

    logic              vld_p1;
    logic              vld_p2;
    logic [DATA_W-1:0] data_p2;

    // p1: read was issued last cycle, SRAM data is on rd_data now
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= rd_en && !flush;
        end
    end

    // p2: output register, zero when not qualified
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2  <= 1'b0;
            data_p2 <= '0;
        end else begin
            vld_p2  <= vld_p1 && !flush;
            data_p2 <= (vld_p1 && !flush) ? rd_data : '0;
        end
    end

    assign out_data  = data_p2;
    assign out_valid = vld_p2;

endmodule

// File: rtl/conv_ifmap_streamer.sv
// Transmit side of the conv pixel-stream interface. Loads the 3x3 kernel from
// SRAM, then for each overlapping row strip pulses conv_start and streams the
// strip's pixels in raster order, waiting for the engine's done pulse before
// moving to the next strip. The interface has no backpressure, so the stream
// runs at one pixel per cycle once started.
module conv_ifmap_streamer
    import conv_pkg::*;
#(
    parameter int DATA_W     = CONV_DATA_W,
    parameter int ADDR_W     = CONV_ADDR_W,
    parameter int IMG_W      = 4,
    parameter int STRIP_ROWS = 4,
    parameter int NUM_STRIPS = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cfg_start,
    input  logic                            cfg_abort,
    input  logic [ADDR_W-1:0]               cfg_ifmap_base,
    input  logic [ADDR_W-1:0]               cfg_kern_base,
    output logic                            mem_en,
    output logic [ADDR_W-1:0]               mem_addr,
    input  logic [DATA_W-1:0]               mem_rdata,
    output logic [KERN_TAPS-1:0][DATA_W-1:0] kernel_num,
    output logic                            conv_start,
    output logic [DATA_W-1:0]               conv_num,
    output logic                            conv_num_valid,
    input  logic                            conv_done,
    output logic                            busy,
    output logic                            frame_done
);

    localparam int PIX_PER_STRIP = IMG_W * STRIP_ROWS;
    localparam int PIX_W         = $clog2(PIX_PER_STRIP + 1);
    localparam int STRIP_W       = $clog2(NUM_STRIPS + 1);
    localparam int K_W           = $clog2(KERN_TAPS + 1);

    localparam logic [PIX_W-1:0]   PIX_LAST   = PIX_W'(PIX_PER_STRIP - 1);
    localparam logic [PIX_W-1:0]   PIX_ONE    = PIX_W'(1);
    localparam logic [STRIP_W-1:0] STRIP_LAST = STRIP_W'(NUM_STRIPS - 1);
    localparam logic [STRIP_W-1:0] STRIP_ONE  = STRIP_W'(1);
    localparam logic [K_W-1:0]     K_LAST     = K_W'(KERN_TAPS - 1);
    localparam logic [K_W-1:0]     K_ONE      = K_W'(1);
    localparam logic [ADDR_W-1:0]  ADDR_ONE   = ADDR_W'(1);

    stream_state_e state_q;

    logic [ADDR_W-1:0]  ifmap_base_q;
    logic [ADDR_W-1:0]  kern_base_q;
    logic [STRIP_W-1:0] strip_q;
    logic [PIX_W-1:0]   pix_q;
    logic [K_W-1:0]     k_q;
    logic               drain_q;
    logic               done_seen_q;

    logic               mem_en_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic               conv_start_q;
    logic               busy_q;
    logic               frame_done_q;

    logic                             kvld_p1;
    logic [K_W-1:0]                   kidx_p1;
    logic [KERN_TAPS-1:0][DATA_W-1:0] kernel_q;

    logic              abort_now;
    logic              pix_rd;
    logic [ADDR_W-1:0] strip_off;

    // Abort only has meaning once a frame is in progress; in IDLE it merely
    // suppresses a coincident start.
    assign abort_now = cfg_abort && (state_q != S_IDLE);

    // Pixel reads are the only reads that feed the stream pipe.
    assign pix_rd = mem_en_q && (state_q == S_STREAM);

    // Strip s starts at row s, so its first pixel is s rows past the base.
    assign strip_off = ADDR_W'(strip_q) * ADDR_W'(IMG_W);

    // Frame sequencer: kernel load, then per strip start pulse, pixel reads,
    // pipe drain and wait for the engine's done. All outputs are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ifmap_base_q <= '0;
            kern_base_q  <= '0;
            strip_q      <= '0;
            pix_q        <= '0;
            k_q          <= '0;
            drain_q      <= 1'b0;
            done_seen_q  <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_addr_q   <= '0;
            conv_start_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else if (abort_now) begin
            state_q      <= S_IDLE;
            done_seen_q  <= 1'b0;
            mem_en_q     <= 1'b0;
            conv_start_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            conv_start_q <= 1'b0;
            frame_done_q <= 1'b0;

            // A done that arrives while the strip is still streaming or
            // draining is remembered so WAIT cannot miss it.
            if (conv_done && (state_q == S_STREAM || state_q == S_SDRAIN ||
                              state_q == S_WAIT)) begin
                done_seen_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (cfg_start && !cfg_abort) begin
                        ifmap_base_q <= cfg_ifmap_base;
                        kern_base_q  <= cfg_kern_base;
                        strip_q      <= '0;
                        k_q          <= '0;
                        mem_en_q     <= 1'b1;
                        mem_addr_q   <= cfg_kern_base;
                        busy_q       <= 1'b1;
                        state_q      <= S_KLOAD;
                    end
                end
                S_KLOAD: begin
                    if (k_q == K_LAST) begin
                        mem_en_q <= 1'b0;
                        state_q  <= S_KDRAIN;
                    end else begin
                        k_q        <= k_q + K_ONE;
                        mem_addr_q <= mem_addr_q + ADDR_ONE;
                    end
                end
                S_KDRAIN: begin
                    conv_start_q <= 1'b1;
                    state_q      <= S_START;
                end
                S_START: begin
                    done_seen_q <= 1'b0;
                    pix_q       <= '0;
                    mem_en_q    <= 1'b1;
                    mem_addr_q  <= ifmap_base_q + strip_off;
                    state_q     <= S_STREAM;
                end
                S_STREAM: begin
                    if (pix_q == PIX_LAST) begin
                        mem_en_q <= 1'b0;
                        drain_q  <= 1'b0;
                        state_q  <= S_SDRAIN;
                    end else begin
                        pix_q      <= pix_q + PIX_ONE;
                        mem_addr_q <= mem_addr_q + ADDR_ONE;
                    end
                end
                S_SDRAIN: begin
                    if (drain_q) begin
                        state_q <= S_WAIT;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    // A done arriving in this very cycle counts too, so the
                    // frame completes one cycle after the engine's pulse.
                    if (done_seen_q || conv_done) begin
                        done_seen_q <= 1'b0;
                        if (strip_q == STRIP_LAST) begin
                            frame_done_q <= 1'b1;
                            state_q      <= S_FIN;
                        end else begin
                            strip_q      <= strip_q + STRIP_ONE;
                            conv_start_q <= 1'b1;
                            state_q      <= S_START;
                        end
                    end
                end
                S_FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Kernel capture: p1 tags the word whose read was issued last cycle; the
    // weights hold until the next frame's kernel load overwrites them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kvld_p1  <= 1'b0;
            kidx_p1  <= '0;
            kernel_q <= '0;
        end else begin
            kvld_p1 <= mem_en_q && (state_q == S_KLOAD) && !abort_now;
            kidx_p1 <= k_q;
            if (kvld_p1 && !abort_now) begin
                kernel_q[kidx_p1] <= mem_rdata;
            end
        end
    end

    conv_rd_pipe #(
        .DATA_W (DATA_W)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (abort_now),
        .rd_en     (pix_rd),
        .rd_data   (mem_rdata),
        .out_data  (conv_num),
        .out_valid (conv_num_valid)
    );

    assign mem_en     = mem_en_q;
    assign mem_addr   = mem_addr_q;
    assign kernel_num = kernel_q;
    assign conv_start = conv_start_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_ifmap_streamer.sv
// Bench for conv_ifmap_streamer: an SRAM model backed by a plain array, a
// conv-engine stand-in that answers each strip with a done pulse, and a
// scoreboard fed from the frame description (addresses and pixel values
// computed directly from base, strip and pixel index).
module tb_conv_ifmap_streamer;

    localparam int DW     = 16;
    localparam int AW     = 16;
    localparam int IMGW   = 4;
    localparam int SROWS  = 4;
    localparam int NSTRIP = 2;
    localparam int PIX    = IMGW * SROWS;
    localparam int NREADS = 9 + NSTRIP * PIX;

    logic                 clk;
    logic                 rst_n;
    logic                 cfg_start;
    logic                 cfg_abort;
    logic [AW-1:0]        cfg_ifmap_base;
    logic [AW-1:0]        cfg_kern_base;
    logic                 mem_en;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_rdata;
    logic [8:0][DW-1:0]   kernel_num;
    logic                 conv_start;
    logic [DW-1:0]        conv_num;
    logic                 conv_num_valid;
    logic                 conv_done;
    logic                 busy;
    logic                 frame_done;

    conv_ifmap_streamer #(
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .IMG_W      (IMGW),
        .STRIP_ROWS (SROWS),
        .NUM_STRIPS (NSTRIP)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_start      (cfg_start),
        .cfg_abort      (cfg_abort),
        .cfg_ifmap_base (cfg_ifmap_base),
        .cfg_kern_base  (cfg_kern_base),
        .mem_en         (mem_en),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .kernel_num     (kernel_num),
        .conv_start     (conv_start),
        .conv_num       (conv_num),
        .conv_num_valid (conv_num_valid),
        .conv_done      (conv_done),
        .busy           (busy),
        .frame_done     (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:65535];
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= mem[mem_addr];
    end

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] exp_addr_q [$];
    logic [DW-1:0] exp_pix_q  [$];
    logic [DW-1:0] exp_w [9];

    int  cyc = 0;
    int  start_cyc = 0;
    int  run_len = 0;
    int  last_run_len = 0;
    int  runs_done = 0;
    int  reads = 0;
    int  starts = 0;
    int  frames_done = 0;
    bit  prev_start = 0;
    bit  expect_short = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every read strobe and every valid pixel.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst_n) begin
            if (prev_start) chk("conv_start_width", conv_start, 0);
            prev_start = conv_start;
            if (conv_start) begin
                starts++;
                start_cyc = cyc;
                for (int k = 0; k < 9; k++) chk($sformatf("kernel_w%0d", k), kernel_num[k], exp_w[k]);
            end
            if (mem_en) begin
                reads++;
                chk("read_pending", exp_addr_q.size() > 0, 1);
                if (exp_addr_q.size() > 0) chk("mem_addr", mem_addr, exp_addr_q.pop_front());
            end
            if (conv_num_valid) begin
                chk("pix_pending", exp_pix_q.size() > 0, 1);
                if (exp_pix_q.size() > 0) chk("conv_num", conv_num, exp_pix_q.pop_front());
                if (run_len == 0) chk("first_valid_latency", cyc - start_cyc, 3);
                run_len++;
            end else if (run_len > 0) begin
                if (!expect_short) chk("valid_run_len", run_len, PIX);
                chk("conv_num_idle_zero", conv_num, 0);
                last_run_len = run_len;
                runs_done++;
                run_len = 0;
            end
            if (frame_done) frames_done++;
        end else begin
            prev_start = 0;
            run_len = 0;
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_mem_en"}, mem_en, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_kernel"}, |kernel_num, 0);
        chk({tag, "_conv_start"}, conv_start, 0);
        chk({tag, "_conv_num"}, conv_num, 0);
        chk({tag, "_valid"}, conv_num_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
    endtask

    // Fill memory and build the expected read/pixel streams for one frame.
    task automatic prep_frame(input logic [AW-1:0] kb, input logic [AW-1:0] ib, input bit rnd);
        logic [AW-1:0] a;
        for (int i = 0; i < IMGW * (SROWS + NSTRIP - 1); i++) begin
            a = ib + AW'(i);
            mem[a] = rnd ? DW'($urandom) : a;
        end
        for (int k = 0; k < 9; k++) begin
            a = kb + AW'(k);
            mem[a] = rnd ? DW'($urandom) : DW'(k + 1);
        end
        for (int k = 0; k < 9; k++) exp_w[k] = mem[kb + AW'(k)];
        exp_addr_q.delete();
        exp_pix_q.delete();
        for (int k = 0; k < 9; k++) exp_addr_q.push_back(kb + AW'(k));
        for (int s = 0; s < NSTRIP; s++) begin
            for (int p = 0; p < PIX; p++) begin
                a = ib + AW'(s * IMGW + p);
                exp_addr_q.push_back(a);
                exp_pix_q.push_back(mem[a]);
            end
        end
        reads = 0;
        starts = 0;
        frames_done = 0;
        expect_short = 0;
        cfg_kern_base = kb;
        cfg_ifmap_base = ib;
        cfg_start = 1'b1;
        tick;
        cfg_start = 1'b0;
    endtask

    task automatic run_frame(input logic [AW-1:0] kb, input logic [AW-1:0] ib, input bit early, input bit rnd);
        int base_runs;
        int d;
        base_runs = runs_done;
        prep_frame(kb, ib, rnd);
        for (int s = 0; s < NSTRIP; s++) begin
            if (early) begin
                for (int i = 0; i < 300 && run_len < 3; i++) tick;
                chk("early_wait_timeout", run_len >= 3, 1);
                conv_done = 1'b1;
                tick;
                conv_done = 1'b0;
            end
            for (int i = 0; i < 300 && runs_done < base_runs + s + 1; i++) tick;
            chk("strip_run_timeout", runs_done >= base_runs + s + 1, 1);
            if (!early) begin
                d = $urandom_range(0, 3);
                repeat (d) tick;
                conv_done = 1'b1;
            end
            tick;
            conv_done = 1'b0;
            if (s == NSTRIP - 1) chk("frame_done_pulse", frame_done, 1);
            else chk("next_strip_start", conv_start, 1);
        end
        tick;
        chk("frame_done_width", frame_done, 0);
        chk("busy_after_frame", busy, 0);
        chk("reads_per_frame", reads, NREADS);
        chk("starts_per_frame", starts, NSTRIP);
        chk("frames_done_count", frames_done, 1);
        chk("addr_queue_drained", exp_addr_q.size(), 0);
        chk("pix_queue_drained", exp_pix_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
        cfg_ifmap_base = '0;
        cfg_kern_base = '0;
        conv_done = 1'b0;
        repeat (3) tick;
        chk_zero("reset");
        rst_n = 1'b1;
        tick;
        chk("idle_busy", busy, 0);

        // Weights 1..9 at 0x100, pixel value equals its address
        run_frame(16'h0100, 16'h0000, 1'b0, 1'b0);
        // Done pulses arrive while each strip is still streaming
        run_frame(16'h0100, 16'h0000, 1'b1, 1'b0);

        // Start and abort together in IDLE: stay idle
        cfg_start = 1'b1;
        cfg_abort = 1'b1;
        tick;
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
        tick;
        chk("start_abort_idle_busy", busy, 0);
        chk("start_abort_idle_mem_en", mem_en, 0);

        // Abort at pixel 7 of strip 0
        prep_frame(16'h0300, 16'h0040, 1'b1);
        for (int i = 0; i < 100 && starts < 1; i++) tick;
        chk("abort_start_timeout", starts, 1);
        repeat (8) tick;
        expect_short = 1'b1;
        cfg_abort = 1'b1;
        tick;
        cfg_abort = 1'b0;
        chk("abort_mem_en", mem_en, 0);
        chk("abort_valid", conv_num_valid, 0);
        chk("abort_busy", busy, 0);
        repeat (6) tick;
        chk("abort_pixels_seen", last_run_len, 6);
        chk("abort_no_frame_done", frames_done, 0);
        chk("abort_single_start", starts, 1);
        chk("abort_reads", reads, 9 + 8);
        for (int k = 0; k < 9; k++) chk($sformatf("abort_kernel_w%0d", k), kernel_num[k], exp_w[k]);
        exp_addr_q.delete();
        exp_pix_q.delete();
        expect_short = 1'b0;

        // Reset in the middle of a strip whose addresses wrap past 0xFFFF
        prep_frame(16'h0200, 16'hFFFE, 1'b1);
        for (int i = 0; i < 100 && starts < 1; i++) tick;
        chk("wrap_start_timeout", starts, 1);
        expect_short = 1'b1;
        repeat (6) tick;
        chk("wrap_reads_before_reset", reads, 9 + 6);
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        tick;
        tick;
        rst_n = 1'b1;
        exp_addr_q.delete();
        exp_pix_q.delete();
        expect_short = 1'b0;
        tick;
        chk("post_reset_busy", busy, 0);

        // Randomized frames: random bases, contents, done timing
        for (int f = 0; f < 8; f++) begin
            run_frame(AW'($urandom), AW'($urandom), 1'($urandom_range(0, 1)), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
